// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial sequence detector.
// Holds the FSM state encoding and a small decode helper used by the top.

package seq_det_pkg;

    localparam int unsigned DefPatternW = 4;
    localparam int unsigned DefCntW     = 8;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFill = 2'd1,
        StRun  = 2'd2
    } state_e;

    function automatic logic state_busy(input state_e s);
        return (s == StFill) || (s == StRun);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.

module sat_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Serial detector for a run-time loadable PATTERN_W-bit pattern (MSB matched first),
// with input qualifier, overlap/non-overlap matching and a saturating match counter.

module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int unsigned          PATTERN_W     = DefPatternW,
    parameter int unsigned          CNT_W         = DefCntW,
    parameter logic [PATTERN_W-1:0] RESET_PATTERN = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic                 overlap_in,
    input  logic                 x_valid,
    input  logic                 x,
    input  logic                 clear_count,
    output logic                 y,
    output logic [CNT_W-1:0]     match_count,
    output logic                 busy
);

    localparam int unsigned      FillW    = $clog2(PATTERN_W + 1);
    localparam logic [FillW-1:0] LastFill = FillW'(PATTERN_W - 1);

    state_e               state_q, state_d;
    logic [PATTERN_W-1:0] hist_q, hist_d;
    logic [PATTERN_W-1:0] pattern_q, pattern_d;
    logic [FillW-1:0]     fill_q, fill_d;
    logic                 overlap_q, overlap_d;
    logic                 y_q, y_d;
    logic                 match;
    logic [PATTERN_W-1:0] shifted;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            hist_q    <= '0;
            pattern_q <= RESET_PATTERN;
            fill_q    <= '0;
            overlap_q <= 1'b0;
            y_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            pattern_q <= pattern_d;
            fill_q    <= fill_d;
            overlap_q <= overlap_d;
            y_q       <= y_d;
        end
    end

    // Next-state logic; load overrides everything and discards the same-cycle bit.
    always_comb begin
        state_d   = state_q;
        hist_d    = hist_q;
        pattern_d = pattern_q;
        fill_d    = fill_q;
        overlap_d = overlap_q;
        match     = 1'b0;
        shifted   = {hist_q[PATTERN_W-2:0], x};

        if (load) begin
            pattern_d = pattern_in;
            overlap_d = overlap_in;
            hist_d    = '0;
            fill_d    = '0;
            state_d   = StFill;
        end else if (x_valid) begin
            unique case (state_q)
                StIdle: begin
                    state_d = StIdle;
                end
                StFill: begin
                    hist_d = shifted;
                    fill_d = fill_q + FillW'(1);
                    if (fill_q == LastFill) begin
                        state_d = StRun;
                        match   = (shifted == pattern_q);
                    end
                end
                StRun: begin
                    hist_d = shifted;
                    match  = (shifted == pattern_q);
                end
                default: begin
                    state_d = StIdle;
                end
            endcase

            // Non-overlap: the next match must be built from PATTERN_W fresh bits.
            if (match && !overlap_q) begin
                fill_d  = '0;
                state_d = StFill;
            end
        end

        y_d = match;
    end

    // Outputs.
    always_comb begin
        y    = y_q;
        busy = state_busy(state_q);
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_sat_counter (
        .clk  (clk),
        .reset(reset),
        .inc  (match),
        .clr  (clear_count),
        .count(match_count)
    );

endmodule
